rr_decoder_arbiter: RTL and testbench
=====================================

// Module: rr_decoder_arbiter
// PURPOSE
//  8-requester round-robin arbiter that shares the 3x8 decoder select path
//  between clients. Each cycle at most one client owns the decoder.
//  The arbiter drives the decoder's 3-bit select and enable, and mirrors the
//  resulting one-hot grant. It sits between the client request lines and the
//  decoder instance.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles a grant may be held (used only with ARB_TIMEOUT_EN); range 1..255
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  req        in   8  request per client; bit i = client i; held high for the whole ownership
//  s          out  3  decoder select = index of granted client
//  enable     out  1  decoder enable; high while a grant is active
//  gnt        out  8  one-hot grant, gnt[i] = enable && (s == i)
//  busy       out  1  high in GRANT state (equal to enable)
//  timeout    out  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  - All outputs are registered. On rst: s=0, enable=0, gnt=0, busy=0, timeout=0,
//    state=IDLE, priority pointer ptr=0, hold counter=0, mask=0.
//  - Reset mid-grant drops the grant on the next edge. No release handshake is performed.
//  - FSM has two states, IDLE and GRANT.
//  - IDLE: if (req & ~mask) != 0, pick the first set bit scanning ptr, ptr+1, ... 7, 0, ... ptr-1
//    (mod 8 wrap). On the next edge: s=idx, enable=1, gnt=1<<idx, state->GRANT,
//    ptr = idx+1 mod 8 (7 -> 0). If no eligible request, stay in IDLE with outputs 0.
//  - Latency: req rising in cycle N (arbiter IDLE) -> gnt visible in cycle N+1.
//  - GRANT: hold while req[s]=1; requests from other clients are ignored.
//    When req[s]=0 at an edge: enable=0, gnt=0, state->IDLE. s keeps its last value.
//  - After every grant there is exactly one IDLE cycle, so back-to-back grants are
//    spaced 1 cycle apart. gnt therefore never shows two clients in consecutive cycles.
//  - Simultaneous requests are resolved only by the ptr scan. A lone requester re-wins
//    every time, even when ptr has moved past it.
//  - A client that drops req before it is granted is simply not selected. No request
//    is latched.
//  - gnt is always one-hot or zero. gnt == 0 whenever enable == 0.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - An 8-bit hold counter clears on grant and increments each GRANT cycle.
//   - When the counter reaches TIMEOUT_CYCLES with req[s] still high: release as for a
//     normal drop, pulse timeout=1 for one cycle, and set mask[s]=1.
//   - mask[i] clears in any cycle where req[i]=0. A masked client is not eligible.
//  ARB_TIMEOUT_EN undefined:
//   - No counter and no mask (mask treated as 0); timeout is constant 0.
//   - Grants are held indefinitely while req[s]=1.
// TESTING
//  1 rst=1 for 2 cycles, then req=8'h00 -> s=0, enable=0, gnt=0, busy=0 on every cycle.
//  2 req=8'h81 held; each client drops req 2 cycles after its grant:
//    -> gnt=8'h01, then 1 idle cycle, then gnt=8'h80, then 1 idle cycle, then 8'h01 again.
//    Checks the 7 -> 0 pointer wrap.
//  3 req=8'hFF, each client holds 1 cycle per grant -> gnt order 01,02,04,...,80,01.
//    s matches the index each time; enable=0 on every gap cycle.
//  4 Client 3 granted (s=3), then rst pulsed for 1 cycle mid-grant -> next cycle all outputs 0
//    and ptr=0. With req=8'h18 afterwards, the next grant is 8'h08.
//  5 ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4; req=8'h04 held forever plus req[5]=1:
//    -> gnt=8'h04 for 4 cycles, timeout pulse, gnt=8'h20 next.
//    Client 2 is not re-granted until req[2] drops and rises again.
//  6 Randomised req over 10k cycles -> assert gnt one-hot-or-zero and gnt==(enable<<s).
//    Assert no client is starved longer than 7 grants while its req is held.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: 8-client round-robin arbiter driving a 3x8 decoder select/enable with one-hot grant mirror.
// Define ARB_TIMEOUT_EN to add forced release after TIMEOUT_CYCLES with per-client masking.
module rr_decoder_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] s,
  output logic       enable,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [2:0] ptr, idx;
  logic found, expire;
  logic [7:0] mask, elig;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  assign elig = req & ~mask;
  // first eligible client scanning upward from ptr with wrap
  always_comb begin
    found = 1'b0;
    idx = ptr;
    for (int k = 0; k < 8; k++) begin
      if (!found && elig[ptr + 3'(k)]) begin
        found = 1'b1;
        idx = ptr + 3'(k);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= 3'd0;
      enable <= 1'b0;
      gnt <= 8'd0;
      busy <= 1'b0;
      ptr <= 3'd0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= GRANT;
        s <= idx;
        enable <= 1'b1;
        busy <= 1'b1;
        gnt <= 8'd1 << idx;
        ptr <= idx + 3'd1;
      end
    end else if (!req[s] || expire) begin
      state <= IDLE;
      enable <= 1'b0;
      busy <= 1'b0;
      gnt <= 8'd0;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = req[s] && cnt == 8'(TIMEOUT_CYCLES - 1);
  // cnt counts completed GRANT cycles; it sits at 0 in IDLE so each grant starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
      mask <= 8'd0;
      timeout <= 1'b0;
    end else begin
      cnt <= (state == GRANT) ? cnt + 8'd1 : 8'd0;
      timeout <= state == GRANT && expire;
      mask <= (mask & req) | ((state == GRANT && expire) ? 8'd1 << s : 8'd0);
    end
  end
`else
  assign expire = 1'b0;
  assign mask = 8'd0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb_rr_decoder_arbiter: directed and randomized checks against a behavioural round-robin model.
module tb_rr_decoder_arbiter;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic [2:0] s;
  logic enable, busy, timeout;
  logic [7:0] gnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_decoder_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .s(s), .enable(enable),
    .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: owner index, pointer, cycles held, mask, starvation counters
  bit m_valid = 1'b0;
  bit m_on, m_to;
  int m_s, m_ptr, m_held;
  bit [7:0] m_mask;
  int waitc [8];

  always @(posedge clk) begin
    bit [7:0] nm;
    int g;
    g = -1;
    if (rst) begin
      m_on = 0; m_to = 0; m_s = 0; m_ptr = 0; m_held = 0; m_mask = 0; m_valid = 1;
      waitc = '{default: 0};
    end else begin
      m_to = 0;
      nm = m_mask & req;
      if (!m_on) begin
        for (int k = 0; k < 8; k++)
          if (g < 0 && req[(m_ptr + k) % 8] && !m_mask[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
        if (g >= 0) begin
          m_on = 1; m_s = g; m_ptr = (g + 1) % 8; m_held = 1;
        end
      end else if (!req[m_s]) m_on = 0;
`ifdef ARB_TIMEOUT_EN
      else if (m_held == T) begin
        m_on = 0; m_to = 1; nm[m_s] = 1;
      end
`endif
      else m_held++;
      m_mask = nm;
      for (int i = 0; i < 8; i++)
        if (!req[i] || m_mask[i] || g == i) waitc[i] = 0;
        else if (g >= 0) waitc[i]++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("s", 32'(s), 32'(m_s));
      chk("enable", 32'(enable), 32'(m_on));
      chk("gnt", 32'(gnt), m_on ? 32'(1) << m_s : 32'd0);
      chk("busy", 32'(busy), 32'(m_on));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("gnt_vs_s", 32'(gnt), enable ? 32'(1) << s : 32'd0);
      for (int i = 0; i < 8; i++) chk("starve", 32'(waitc[i] <= 7), 32'd1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 8'd0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_en", 32'(enable), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
  endtask

  logic [7:0] t2_exp [8] = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00, 8'h01, 8'h00};
  logic [7:0] t2_drv [8] = '{8'h81, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h00, 8'h00};

  initial begin
    logic [7:0] e;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_en", 32'(enable), 32'd0);
    end
    do_reset();
    req = 8'h81;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("wrap_gnt", 32'(gnt), 32'(t2_exp[k]));
      req = t2_drv[k];
    end
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      e = (k % 2 == 0) ? 8'd1 << ((k / 2) % 8) : 8'd0;
      chk("rr_gnt", 32'(gnt), 32'(e));
      chk("rr_en", 32'(enable), 32'(e != 0));
      if (e != 0) chk("rr_s", 32'(s), 32'((k / 2) % 8));
      req = (e != 0) ? ~e : 8'hFF;
    end
    do_reset();
    req = 8'h08;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h08);
    chk("mid_s", 32'(s), 32'd3);
    rst = 1'b1;
    req = 8'h18;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_en", 32'(enable), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h08);
`ifdef ARB_TIMEOUT_EN
    do_reset();
    req = 8'h24;
    repeat (4) begin
      @(negedge clk);
      chk("to_hold", 32'(gnt), 32'h04);
    end
    @(negedge clk);
    chk("to_gap", 32'(gnt), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    @(negedge clk);
    chk("to_next", 32'(gnt), 32'h20);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    req = 8'h04;
    @(negedge clk);
    chk("to_rel", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("to_masked", 32'(gnt), 32'd0);
    req = 8'h00;
    @(negedge clk);
    chk("to_clear", 32'(gnt), 32'd0);
    req = 8'h04;
    @(negedge clk);
    chk("to_regrant", 32'(gnt), 32'h04);
`endif
    do_reset();
    repeat (10000) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) req = 8'($urandom);
      else if ($urandom_range(7) == 0) req = req ^ (8'd1 << $urandom_range(7));
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
